// File: rtl/bus_if_pkg.sv
// Shared types and constants for the CPU-side bus interface: FSM states,
// active-low strobe levels, bus widths and address field positions.
package bus_if_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACCESS = 2'd2,
        STALL  = 2'd3
    } bus_if_state_e;

    localparam int WORD_ADDR_W   = 30;
    localparam int WORD_DATA_W   = 32;
    localparam int SPM_ADDR_W    = 12;
    localparam int SLAVE_IDX_MSB = 29;
    localparam int SLAVE_IDX_LSB = 27;

    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    function automatic logic [2:0] slave_index(input logic [WORD_ADDR_W-1:0] a);
        return a[SLAVE_IDX_MSB:SLAVE_IDX_LSB];
    endfunction

endpackage

// File: rtl/bus_if.sv
// Per-stage bus interface: scratchpad accesses bypass the bus with no stall,
// everything else goes through a request/grant/ready sequence on the system bus.
module bus_if
    import bus_if_pkg::*;
#(
    parameter logic [2:0] SPM_INDEX = 3'h1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   flush,
    output logic                   busy,
    input  logic [WORD_ADDR_W-1:0] addr,
    input  logic                   as_,
    input  logic                   rw,
    input  logic [WORD_DATA_W-1:0] wr_data,
    output logic [WORD_DATA_W-1:0] rd_data,
    output logic [SPM_ADDR_W-1:0]  spm_addr,
    output logic                   spm_as_,
    output logic                   spm_rw,
    output logic [WORD_DATA_W-1:0] spm_wr_data,
    input  logic [WORD_DATA_W-1:0] spm_rd_data,
    output logic                   bus_req_,
    input  logic                   bus_grnt_,
    output logic [WORD_ADDR_W-1:0] bus_addr,
    output logic                   bus_as_,
    output logic                   bus_rw,
    output logic [WORD_DATA_W-1:0] bus_wr_data,
    input  logic [WORD_DATA_W-1:0] bus_rd_data,
    input  logic                   bus_rdy_,
    output bus_if_state_e          state
);

    logic [WORD_DATA_W-1:0] rd_buf;
    logic                   spm_sel_q;
    logic                   hit;
    logic                   go;

    assign hit = (slave_index(addr) == SPM_INDEX);
    assign go  = (state == IDLE) && !flush && !stall && (as_ == ENABLE_);

    assign spm_addr    = addr[SPM_ADDR_W-1:0];
    assign spm_rw      = rw;
    assign spm_wr_data = wr_data;
    assign spm_as_     = (go && hit) ? ENABLE_ : DISABLE_;
    assign rd_data     = spm_sel_q ? spm_rd_data : rd_buf;

    always_comb begin
        busy = 1'b0;
        case (state)
            IDLE:    busy = go && !hit;
            REQ:     busy = 1'b1;
            ACCESS:  busy = (bus_rdy_ == DISABLE_);
            STALL:   busy = 1'b0;
            default: busy = 1'b0;
        endcase
    end

    // Bus handshake: bus_req_ is held low from acceptance until the cycle the
    // slave returns bus_rdy_ low; bus_as_ pulses low for the single cycle after
    // bus_grnt_ is seen, and bus_rdy_ only counts once that pulse has been sent.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            bus_req_    <= DISABLE_;
            bus_as_     <= DISABLE_;
            bus_addr    <= '0;
            bus_rw      <= READ;
            bus_wr_data <= '0;
            rd_buf      <= '0;
            spm_sel_q   <= 1'b0;
        end else begin
            spm_sel_q <= go && hit && (rw == READ);
            case (state)
                IDLE: begin
                    if (go && !hit) begin
                        bus_req_    <= ENABLE_;
                        bus_addr    <= addr;
                        bus_rw      <= rw;
                        bus_wr_data <= wr_data;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    if (bus_grnt_ == ENABLE_) begin
                        bus_as_ <= ENABLE_;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    bus_as_ <= DISABLE_;
                    if (bus_rdy_ == ENABLE_) begin
                        bus_req_ <= DISABLE_;
                        if (bus_rw == READ) begin
                            rd_buf <= bus_rd_data;
                        end
                        state <= stall ? STALL : IDLE;
                    end
                end
                STALL: begin
                    if (!stall) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_if.sv
// Randomized bench for bus_if: stage driver, arbiter/slave and scratchpad
// models, and a monitor that checks read data against a transaction-level model.
module tb_bus_if;
    import bus_if_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, flush, busy;
    logic [29:0] addr;
    logic        as_, rw;
    logic [31:0] wr_data, rd_data;
    logic [11:0] spm_addr;
    logic        spm_as_, spm_rw;
    logic [31:0] spm_wr_data, spm_rd_data;
    logic        bus_req_, bus_grnt_;
    logic [29:0] bus_addr;
    logic        bus_as_, bus_rw;
    logic [31:0] bus_wr_data, bus_rd_data;
    logic        bus_rdy_;
    bus_if_state_e state;

    bus_if #(.SPM_INDEX(3'h1)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .busy(busy),
        .addr(addr), .as_(as_), .rw(rw), .wr_data(wr_data), .rd_data(rd_data),
        .spm_addr(spm_addr), .spm_as_(spm_as_), .spm_rw(spm_rw),
        .spm_wr_data(spm_wr_data), .spm_rd_data(spm_rd_data),
        .bus_req_(bus_req_), .bus_grnt_(bus_grnt_), .bus_addr(bus_addr),
        .bus_as_(bus_as_), .bus_rw(bus_rw), .bus_wr_data(bus_wr_data),
        .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_), .state(state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    // Reference model: what the stage should observe, by address.
    logic [31:0] ref_spm [0:4095];
    logic [31:0] ref_bus [logic [29:0]];
    logic [31:0] ref_rd_buf;

    // Peripheral contents as actually written by the DUT.
    logic [31:0] spm_mem [0:4095];
    logic [31:0] bus_mem [logic [29:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Synchronous scratchpad RAM, one-cycle read latency.
    initial begin
        spm_rd_data = '0;
        forever begin
            @(posedge clk);
            if (!spm_as_ && spm_rw == WRITE) spm_mem[spm_addr] = spm_wr_data;
            spm_rd_data = spm_mem[spm_addr];
        end
    end

    // Arbiter plus slave: random grant and ready latency, junk ready before the strobe.
    initial begin
        int ph, gd, rd;
        logic [29:0] cap_addr;
        logic        cap_rw;
        logic [31:0] cap_wd;
        ph = 0; gd = 0; rd = 0;
        cap_addr = '0; cap_rw = READ; cap_wd = '0;
        bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = '0;
        forever begin
            @(posedge clk); #1;
            bus_rd_data = $urandom;
            if (!reset || bus_req_) begin
                bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; ph = 0;
            end else begin
                if (ph == 0) begin gd = $urandom_range(0, 2); ph = 1; end
                if (ph == 1) begin
                    bus_rdy_ = 1'($urandom_range(0, 1));
                    if (gd == 0) begin bus_grnt_ = 1'b0; ph = 2; end
                    else gd--;
                end else if (ph == 2) begin
                    bus_rdy_ = 1'b1;
                    if (!bus_as_) begin
                        cap_addr = bus_addr; cap_rw = bus_rw; cap_wd = bus_wr_data;
                        rd = $urandom_range(0, 3);
                        ph = 3;
                    end
                end else if (ph == 3) begin
                    if (rd > 0) rd--;
                end else begin
                    bus_rdy_ = 1'b1;
                end
                if (ph == 3) begin
                    if (rd == 0) begin
                        bus_rdy_ = 1'b0;
                        if (cap_rw == READ) bus_rd_data = bus_mem.exists(cap_addr) ? bus_mem[cap_addr] : 32'h0;
                        else bus_mem[cap_addr] = cap_wd;
                        ph = 4;
                    end else begin
                        bus_rdy_ = 1'b1;
                    end
                end
            end
        end
    end

    // Monitor: read data due the cycle after an SPM read or any bus completion.
    initial begin
        logic spm_pend, bus_pend;
        int   as_cnt;
        spm_pend = 1'b0; bus_pend = 1'b0; as_cnt = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                spm_pend = 1'b0; bus_pend = 1'b0; as_cnt = 0;
            end else begin
                if (spm_pend || bus_pend) begin
                    if (exp_q.size() == 0) check("unexpected_rd", 32'h1, 32'h0);
                    else check("rd_data", rd_data, exp_q.pop_front());
                end
                spm_pend = 1'b0; bus_pend = 1'b0;
                if (!spm_as_) begin
                    check("spm_busy", {31'h0, busy}, 32'h0);
                    if (spm_rw == READ) spm_pend = 1'b1;
                end
                if (!bus_as_) as_cnt++;
                if (bus_req_) begin
                    if (!bus_as_) check("as_without_req", {31'h0, bus_as_}, 32'h1);
                    as_cnt = 0;
                end else if (!bus_rdy_ && as_cnt > 0) begin
                    check("as_pulse", as_cnt, 32'd1);
                    check("done_busy", {31'h0, busy}, 32'h0);
                    bus_pend = 1'b1;
                end else begin
                    check("req_busy", {31'h0, busy}, 32'h1);
                end
            end
        end
    end

    function automatic logic [29:0] rand_spm_addr();
        return {3'h1, 15'($urandom), 9'h0, 3'($urandom_range(0, 7))};
    endfunction

    function automatic logic [29:0] rand_bus_addr();
        logic [2:0] s;
        s = 3'($urandom_range(0, 6));
        if (s >= 3'h1) s = s + 3'h1;
        return {s, 24'h0, 3'($urandom_range(0, 7))};
    endfunction

    // Entered and left at 1 time unit after a rising edge with the DUT in IDLE.
    task automatic do_access(input logic [29:0] a, input logic r, input logic [31:0] d,
                             input logic ask_stall, input logic ask_flush);
        logic hit, b, stalled;
        logic [31:0] v;
        int n, k;
        hit = (a[29:27] == 3'h1);
        addr = a; rw = r; wr_data = d; as_ = 1'b0; stall = 1'b0; flush = 1'b0;
        if (hit) begin
            if (r == READ) exp_q.push_back(ref_spm[a[11:0]]);
            else ref_spm[a[11:0]] = d;
        end else if (r == READ) begin
            v = ref_bus.exists(a) ? ref_bus[a] : 32'h0;
            exp_q.push_back(v);
            ref_rd_buf = v;
        end else begin
            ref_bus[a] = d;
            exp_q.push_back(ref_rd_buf);
        end
        n = 0;
        forever begin
            @(negedge clk); b = busy;
            @(posedge clk); #1;
            if (!b) break;
            if (n == 0) begin stall = ask_stall; flush = ask_flush; end
            n++;
            if (n > 200) begin check("access_timeout", 32'h1, 32'h0); break; end
        end
        stalled = stall;
        as_ = 1'b1; flush = 1'b0;
        if (stalled) begin
            k = $urandom_range(0, 2);
            repeat (k) begin
                @(negedge clk);
                check("stall_state", state, STALL);
                check("stall_busy", {31'h0, busy}, 32'h0);
                check("stall_req", {31'h0, bus_req_}, 32'h1);
                @(posedge clk); #1;
            end
            stall = 1'b0; addr = rand_spm_addr(); rw = READ; as_ = 1'b0;
            @(negedge clk);
            check("stall_no_accept", {31'h0, spm_as_}, 32'h1);
            @(posedge clk); #1;
            as_ = 1'b1;
            check("stall_exit", state, IDLE);
        end
        stall = 1'b0;
    endtask

    task automatic cancel_access(input logic use_flush);
        addr = $urandom_range(0, 1) ? rand_spm_addr() : rand_bus_addr();
        rw = 1'($urandom_range(0, 1)); wr_data = $urandom; as_ = 1'b0;
        flush = use_flush; stall = !use_flush;
        @(negedge clk);
        check("cancel_busy", {31'h0, busy}, 32'h0);
        check("cancel_spm_as", {31'h0, spm_as_}, 32'h1);
        @(posedge clk); #1;
        check("cancel_req", {31'h0, bus_req_}, 32'h1);
        check("cancel_state", state, IDLE);
        as_ = 1'b1; flush = 1'b0; stall = 1'b0;
    endtask

    task automatic reset_mid_access();
        int n;
        addr = 30'h1000_0020; rw = READ; wr_data = '0; as_ = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (bus_as_ && n < 50);
        check("mid_reach_access", state, ACCESS);
        #1 reset = 1'b0;
        #1;
        check("mid_reset_req", {31'h0, bus_req_}, 32'h1);
        check("mid_reset_as", {31'h0, bus_as_}, 32'h1);
        check("mid_reset_state", state, IDLE);
        as_ = 1'b1;
        ref_rd_buf = 32'h0;
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("mid_reset_rd_data", rd_data, 32'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) begin ref_spm[i] = '0; spm_mem[i] = '0; end
        ref_rd_buf = '0;
        reset = 1'b0; stall = 1'b0; flush = 1'b0; addr = '0; as_ = 1'b1;
        rw = READ; wr_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_spm_as", {31'h0, spm_as_}, 32'h1);
        check("rst_bus_req", {31'h0, bus_req_}, 32'h1);
        check("rst_bus_as", {31'h0, bus_as_}, 32'h1);
        check("rst_bus_addr", {2'b0, bus_addr}, 32'h0);
        check("rst_bus_rw", {31'h0, bus_rw}, {31'h0, READ});
        check("rst_bus_wr_data", bus_wr_data, 32'h0);
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_state", state, IDLE);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;

        do_access(30'h0800_0004, WRITE, 32'hDEAD_BEEF, 1'b0, 1'b0);
        do_access(30'h0800_0004, READ, 32'h0, 1'b0, 1'b0);
        do_access(30'h1000_0010, WRITE, 32'h1234_5678, 1'b0, 1'b0);
        do_access(30'h1000_0010, READ, 32'h0, 1'b0, 1'b0);
        do_access(30'h1000_0010, WRITE, 32'hCAFE_F00D, 1'b1, 1'b0);
        do_access(30'h1000_0010, READ, 32'h0, 1'b0, 1'b1);
        cancel_access(1'b1);
        cancel_access(1'b0);
        reset_mid_access();
        do_access(30'h1000_0010, READ, 32'h0, 1'b0, 1'b0);

        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                cancel_access(1'($urandom_range(0, 1)));
            end else begin
                do_access($urandom_range(0, 1) ? rand_spm_addr() : rand_bus_addr(),
                          1'($urandom_range(0, 1)), $urandom,
                          ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
            end
        end

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
